fetch_unit: RTL and testbench

- Instruction-fetch stage of the 8-bit pipelined core. Directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives the instruction-memory address.
- Supplies {pc+1, instruction} plus a flush request to IF/ID.
- Loads the reset vector on start-up, follows branch/jump redirects from later stages, honours hazard stalls, and performs interrupt entry through a vector fetch.

---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_pc_reg.sv | 29 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants for the 8-bit pipelined core.
// Holds the datapath width, the vector addresses, the fetch-state encoding and the NOP opcode.
package core_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] RESET_VEC_ADDR = 8'h00;
    localparam logic [DATA_W-1:0] INT_VEC_ADDR   = 8'h01;

    localparam logic [1:0] FS_VEC = 2'd0;
    localparam logic [1:0] FS_RUN = 2'd1;
    localparam logic [1:0] FS_INT = 2'd2;

    localparam logic [DATA_W-1:0] NOP_OPCODE = 8'h00;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load, increment or hold, with asynchronous clear.
// Load takes priority over increment.
module fetch_pc_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [DATA_W-1:0] o_pc
);

    logic [DATA_W-1:0] r_pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + DATA_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reset-vector load, redirects, stalls and interrupt entry via a vector fetch.
// Feeds {pc+1, instruction, flush} to the IF/ID register.
module fetch_unit #(
    parameter int                          DATA_W         = core_pkg::DATA_W,
    parameter logic [core_pkg::DATA_W-1:0] RESET_VEC_ADDR = core_pkg::RESET_VEC_ADDR,
    parameter logic [core_pkg::DATA_W-1:0] INT_VEC_ADDR   = core_pkg::INT_VEC_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    input  logic              intr,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] ifid_pc,
    output logic [DATA_W-1:0] ifid_instr,
    output logic              ifid_flush,
    output logic              intr_ack,
    output logic [DATA_W-1:0] intr_ret_pc
);

    import core_pkg::*;

    logic [1:0]        r_state;
    logic              r_intr_pending;
    logic [DATA_W-1:0] r_intr_ret_pc;

    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_pc;
    logic              w_in_run;
    logic              w_entry;
    logic              w_load;
    logic              w_inc;
    logic [DATA_W-1:0] w_load_val;

    assign w_in_run = (r_state == FS_RUN);
    // A redirect outranks interrupt entry; the interrupt stays pending for the next cycle.
    assign w_entry  = w_in_run && !redirect_valid && r_intr_pending && pc_write;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = imem_data;
        w_inc       = 1'b0;
        case (r_state)
            FS_VEC, FS_INT: begin
                w_load      = 1'b1;
                w_state_nxt = FS_RUN;
            end
            FS_RUN: begin
                if (redirect_valid) begin
                    w_load     = 1'b1;
                    w_load_val = redirect_pc;
                end else if (w_entry) begin
                    w_state_nxt = FS_INT;
                end else if (pc_write) begin
                    w_inc = 1'b1;
                end
            end
            default: w_state_nxt = FS_VEC;
        endcase
    end

    fetch_pc_reg #(
        .DATA_W(DATA_W)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_inc      (w_inc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= FS_VEC;
            r_intr_pending <= 1'b0;
            r_intr_ret_pc  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A request arriving in the entry cycle re-arms pending instead of being lost.
            if (intr) begin
                r_intr_pending <= 1'b1;
            end else if (w_entry) begin
                r_intr_pending <= 1'b0;
            end
            if (w_entry) begin
                r_intr_ret_pc <= w_pc;
            end
        end
    end

    always_comb begin
        case (r_state)
            FS_VEC:  imem_addr = RESET_VEC_ADDR;
            FS_INT:  imem_addr = INT_VEC_ADDR;
            default: imem_addr = w_pc;
        endcase
    end

    assign ifid_pc     = w_pc + DATA_W'(1);
    assign ifid_instr  = w_in_run ? imem_data : NOP_OPCODE;
    assign ifid_flush  = !w_in_run || redirect_valid || w_entry;
    assign intr_ack    = w_entry;
    assign intr_ret_pc = r_intr_ret_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random stimulus,
// compared cycle by cycle against a procedural model of the fetch rules.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pc_write = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       intr = 1'b0;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] ifid_pc;
    logic [7:0] ifid_instr;
    logic       ifid_flush;
    logic       intr_ack;
    logic [7:0] intr_ret_pc;

    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: phase 0 = fetching reset vector, 1 = running, 2 = fetching interrupt vector.
    int       m_phase = 0;
    bit [7:0] m_pc    = 8'h00;
    bit [7:0] m_ret   = 8'h00;
    bit       m_pend  = 1'b0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .intr           (intr),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr),
        .ifid_flush     (ifid_flush),
        .intr_ack       (intr_ack),
        .intr_ret_pc    (intr_ret_pc)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 8'h00;
        m_ret   = 8'h00;
        m_pend  = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs, advance the model.
    task automatic step(input bit pw, input bit rv, input logic [7:0] rpc, input bit it);
        bit [7:0] e_addr;
        bit       e_ack;
        bit       e_flush;
        @(negedge clk);
        pc_write       = pw;
        redirect_valid = rv;
        redirect_pc    = rpc;
        intr           = it;
        #1;
        e_addr  = (m_phase == 0) ? 8'h00 : (m_phase == 2) ? 8'h01 : m_pc;
        e_ack   = (m_phase == 1) && !rv && m_pend && pw;
        e_flush = (m_phase != 1) || rv || e_ack;
        check("imem_addr", imem_addr, e_addr);
        check("ifid_flush", ifid_flush, e_flush);
        check("intr_ack", intr_ack, e_ack);
        check("intr_ret_pc", intr_ret_pc, m_ret);
        if (m_phase == 1) begin
            check("ifid_pc", ifid_pc, (int'(m_pc) + 1) % 256);
            check("ifid_instr", ifid_instr, mem[m_pc]);
        end
        if (m_phase != 1) begin
            m_pc    = mem[e_addr];
            m_phase = 1;
        end else if (rv) begin
            m_pc = rpc;
        end else if (e_ack) begin
            m_ret   = m_pc;
            m_phase = 2;
        end else if (pw) begin
            m_pc = 8'((int'(m_pc) + 1) % 256);
        end
        if (it) m_pend = 1'b1;
        else if (e_ack) m_pend = 1'b0;
    endtask

    // Assert reset between edges and verify the outputs clear without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_intr_ack", intr_ack, 1'b0);
        check("rst_intr_ret_pc", intr_ret_pc, 8'h00);
        check("rst_ifid_flush", ifid_flush, 1'b1);
        check("rst_pc_zero", ifid_pc, 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h20;
        mem[8'h01] = 8'h80;
        mem[8'h20] = 8'hA5;
        mem[8'h21] = 8'h3C;
        mem[8'h22] = 8'h55;
        mem[8'h40] = 8'h77;
        mem[8'hFF] = 8'hE1;
        mem[8'h60] = 8'h6B;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", intr_ack, 1'b0);
        check("reset_ret_pc", intr_ret_pc, 8'h00);
        rst = 1'b0;

        // Reset vector fetch, run and stall.
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Redirect while stalled, redirect to FF, wrap to 00.
        step(0, 1, 8'h40, 0);
        step(1, 1, 8'hFF, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Interrupt entry from pc 40.
        step(1, 1, 8'h3F, 0);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Interrupt held off by a stall.
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Interrupt together with a redirect: redirect wins, entry follows.
        step(1, 1, 8'h60, 1);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Asynchronous reset while fetching the interrupt vector.
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);
        async_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 96) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                     8'($urandom), $urandom_range(0, 5) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
